// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 UART transmitter fed by a small byte FIFO.
// Frames go out back-to-back whenever the FIFO holds another byte at stop-bit end.
module uart_tx_ctrl #(
  parameter int CLK_DIV = 10417,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic               tx_done_sig,
  output logic [FIFO_AW:0]   fifo_level
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, done_q, done_d;
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0] lvl_q, lvl_d;
  logic [7:0] mem_q [DEPTH];
  logic push, pop, empty, bit_end;
  assign empty = lvl_q == '0;
  assign tx_ready = lvl_q != (FIFO_AW+1)'(DEPTH);
  assign push = tx_valid & tx_ready;
  assign bit_end = (state_q != IDLE) && (cnt_q == DIV_M1);
  assign uart_tx = tx_q;
  assign tx_done_sig = done_q;
  assign fifo_level = lvl_q;
  assign tx_busy = (state_q != IDLE) || !empty;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shift_d = mem_q[rd_q];
        state_d = START;
      end
      START: if (bit_end) begin
        state_d = DATA;
        idx_d = 3'd0;
      end
      DATA: if (bit_end) begin
        state_d = (idx_q == 3'd7) ? STOP : DATA;
        idx_d = idx_q + 3'd1;
      end
      STOP: if (bit_end) begin
        // Chain straight into the next start bit when another byte is waiting.
        pop = !empty;
        shift_d = empty ? shift_q : mem_q[rd_q];
        state_d = empty ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = ((state_q == IDLE) || bit_end) ? 16'd0 : cnt_q + 16'd1;
    lvl_d = lvl_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[idx_d] : 1'b1;
    done_d = (state_q == STOP) && bit_end;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
      done_q <= done_d;
      wr_q <= wr_q + FIFO_AW'(push);
      rd_q <= rd_q + FIFO_AW'(pop);
      lvl_q <= lvl_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end
endmodule
